// File: rtl/card_pkg.sv
// card_shoe shared types: card encoding, deck size, LFSR
// width/taps and shoe state enum.
package card_pkg;

   typedef logic [5:0] card_t;
   typedef logic [3:0] rank_t;
   typedef logic [1:0] suit_t;

   localparam int DECK_SIZE = 52;

   localparam int          LFSR_W    = 16;
   // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      S_SHUFFLE = 2'd0,
      S_READY   = 2'd1,
      S_EMPTY   = 2'd2
   } shoe_state_t;

   // Smallest 2^n-1 that is >= i (bit smear)
   function automatic logic [5:0] idx_mask(input logic [5:0] i);
      logic [5:0] m;
      m = i | (i >> 1);
      m = m | (m >> 2);
      m = m | (m >> 4);
      return m;
   endfunction

   // Canonical deck slot k: suit k/13, rank k%13+1
   function automatic card_t canon(input int k);
      suit_t s;
      rank_t r;
      s = suit_t'(k / 13);
      r = rank_t'((k % 13) + 1);
      return {s, r};
   endfunction

endpackage

// File: rtl/card_shoe_if.sv
// card_shoe request/deliver bundle.
// master: game controller side; slave: the shoe.
interface card_shoe_if;
   import card_pkg::*;

   logic        i_shuffle;
   logic        i_entropy;
   logic        i_draw_req;
   card_t       o_card;
   logic        o_card_valid;
   logic        o_ready;
   logic        o_empty;
   logic [5:0]  o_cards_left;

   modport master (
      output i_shuffle, i_entropy, i_draw_req,
      input  o_card, o_card_valid, o_ready,
      input  o_empty, o_cards_left
   );

   modport slave (
      input  i_shuffle, i_entropy, i_draw_req,
      output o_card, o_card_valid, o_ready,
      output o_empty, o_cards_left
   );

endinterface

// File: rtl/card_shoe_lfsr.sv
// 16-bit Fibonacci LFSR with entropy mixing from a free-running
// counter. Ports: i_clk, i_reset, i_entropy in; o_lfsr out.
module card_shoe_lfsr
   import card_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = 16'hACE1
)(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_entropy,
   output logic [LFSR_W-1:0] o_lfsr
);

   logic [LFSR_W-1:0] r_lfsr;
   logic [LFSR_W-1:0] r_cnt;
   logic [LFSR_W-1:0] w_step;
   logic [LFSR_W-1:0] w_mix;
   logic [LFSR_W-1:0] w_next;

   always_comb begin
      w_step = {r_lfsr[LFSR_W-2:0], ^(r_lfsr & LFSR_TAPS)};
      w_mix  = i_entropy ? (w_step ^ r_cnt) : w_step;
      // a zero state would lock the LFSR up
      w_next = (w_mix == '0) ? LFSR_SEED : w_mix;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_lfsr <= LFSR_SEED;
         r_cnt  <= '0;
      end else begin
         r_lfsr <= w_next;
         r_cnt  <= r_cnt + 1'b1;
      end
   end

   assign o_lfsr = r_lfsr;

endmodule

// File: rtl/card_shoe.sv
// 52-card shoe: in-place Fisher-Yates shuffle, one card per draw.
// Ports: i_clk, i_reset, io_shoe (card_shoe_if.slave).
// Macro CARD_SHOE_AUTO_RESHUFFLE_EN: reshuffle instead of S_EMPTY.
module card_shoe
   import card_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = 16'hACE1
)(
   input  logic        i_clk,
   input  logic        i_reset,
   card_shoe_if.slave  io_shoe
);

   logic [LFSR_W-1:0] w_lfsr;

   card_shoe_lfsr #(
      .LFSR_SEED (LFSR_SEED)
   ) u_lfsr (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_entropy (io_shoe.i_entropy),
      .o_lfsr    (w_lfsr)
   );

   shoe_state_t r_state;
   card_t       r_deck [DECK_SIZE];
   logic [5:0]  r_i;
   logic [5:0]  r_top;
   card_t       r_card;
   logic        r_valid;
   logic        r_ready;
   logic        r_empty;

   logic [5:0]  w_mask;
   logic [5:0]  w_cand;
   logic        w_accept;
   logic        w_last;

   always_comb begin
      w_mask   = idx_mask(r_i);
      w_cand   = w_lfsr[5:0] & w_mask;
      // out-of-range candidates are rejected, keeping it unbiased
      w_accept = (w_cand <= r_i);
      w_last   = (r_top == 6'(DECK_SIZE - 1));
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_SHUFFLE;
         r_i     <= 6'(DECK_SIZE - 1);
         r_top   <= '0;
         r_card  <= '0;
         r_valid <= 1'b0;
         r_ready <= 1'b0;
         r_empty <= 1'b0;
         for (int k = 0; k < DECK_SIZE; k++) begin
            r_deck[k] <= canon(k);
         end
      end else begin
         r_valid <= 1'b0;
         unique case (r_state)
            S_SHUFFLE: begin
               r_empty <= 1'b0;
               if (w_accept) begin
                  r_deck[r_i]    <= r_deck[w_cand];
                  r_deck[w_cand] <= r_deck[r_i];
                  if (r_i == 6'd1) begin
                     r_state <= S_READY;
                     r_ready <= 1'b1;
                     r_top   <= '0;
                  end else begin
                     r_i <= r_i - 1'b1;
                  end
               end
            end
            S_READY: begin
               if (io_shoe.i_shuffle) begin
                  r_state <= S_SHUFFLE;
                  r_i     <= 6'(DECK_SIZE - 1);
                  r_top   <= '0;
                  r_ready <= 1'b0;
                  r_empty <= 1'b0;
               end else if (io_shoe.i_draw_req) begin
                  r_card  <= r_deck[r_top];
                  r_valid <= 1'b1;
                  if (w_last) begin
                     r_ready <= 1'b0;
                     r_empty <= 1'b1;
`ifdef CARD_SHOE_AUTO_RESHUFFLE_EN
                     r_state <= S_SHUFFLE;
                     r_i     <= 6'(DECK_SIZE - 1);
                     r_top   <= '0;
`else
                     r_state <= S_EMPTY;
                     r_top   <= r_top + 1'b1;
`endif
                  end else begin
                     r_top <= r_top + 1'b1;
                  end
               end
            end
            S_EMPTY: begin
               if (io_shoe.i_shuffle) begin
                  r_state <= S_SHUFFLE;
                  r_i     <= 6'(DECK_SIZE - 1);
                  r_top   <= '0;
                  r_ready <= 1'b0;
                  r_empty <= 1'b0;
               end
            end
            default: begin
               r_state <= S_SHUFFLE;
               r_i     <= 6'(DECK_SIZE - 1);
               r_top   <= '0;
               r_ready <= 1'b0;
               r_empty <= 1'b0;
            end
         endcase
      end
   end

   assign io_shoe.o_card       = r_card;
   assign io_shoe.o_card_valid = r_valid;
   assign io_shoe.o_ready      = r_ready;
   assign io_shoe.o_empty      = r_empty;
   assign io_shoe.o_cards_left = 6'(DECK_SIZE) - r_top;

endmodule
